cpm_ingress_arb: RTL and testbench

// - Shares the single CPM stream input among N_SRC independent packet sources.
// - Arbitration is round-robin with a per-grant burst lock of up to MAX_BURST beats.
// - The winning beat passes through a one-entry registered stage that drives the CPM in_* port.
// - Sits between the source interfaces and the CPM stream input.

---
 rtl/cpm_arb_pkg.sv | 20 ++
 rtl/cpm_rr_pick.sv | 24 ++
 rtl/cpm_ingress_arb.sv | 110 +++++++++++
 tb/tb_cpm_ingress_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpm_arb_pkg.sv
// cpm_arb_pkg: shared types and index helper for the CPM ingress arbiter.
package cpm_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

    localparam int ARB_ID_W  = 4;
    localparam int ARB_OP_W  = 4;
    localparam int ARB_PAY_W = 16;

    typedef struct packed {
        logic [ARB_ID_W-1:0]  id;
        logic [ARB_OP_W-1:0]  opcode;
        logic [ARB_PAY_W-1:0] payload;
    } arb_beat_t;

    function automatic int rr_next(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/cpm_rr_pick.sv
// cpm_rr_pick: first valid requester at or after start, wrapping modulo N_SRC.
module cpm_rr_pick #(
    parameter  int N_SRC = 4,
    localparam int SW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] valid,
    input  logic [SW-1:0]    start,
    output logic [SW-1:0]    sel,
    output logic             sel_valid
);

    // Scan from farthest to nearest so the closest valid index wins last.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (valid[(int'(start) + i) % N_SRC]) begin
                sel       = SW'((int'(start) + i) % N_SRC);
                sel_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpm_ingress_arb.sv
// cpm_ingress_arb: round-robin burst-lock arbiter feeding one registered CPM stream stage.
module cpm_ingress_arb
    import cpm_arb_pkg::*;
#(
    parameter  int N_SRC     = 4,
    parameter  int MAX_BURST = 4,
    parameter  int ID_W      = 4,
    parameter  int OP_W      = 4,
    parameter  int PAY_W     = 16,
    localparam int SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_en,
    input  logic [N_SRC-1:0]            src_valid,
    output logic [N_SRC-1:0]            src_ready,
    input  logic [N_SRC-1:0][ID_W-1:0]  src_id,
    input  logic [N_SRC-1:0][OP_W-1:0]  src_opcode,
    input  logic [N_SRC-1:0][PAY_W-1:0] src_payload,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             out_id,
    output logic [OP_W-1:0]             out_opcode,
    output logic [PAY_W-1:0]            out_payload,
    output logic [SW-1:0]               out_src,
    output logic [31:0]                 grant_cnt
);

    arb_state_t state_q, state_d;
    logic [SW-1:0] rr_q, rr_d, owner_q, owner_d;
    logic [3:0] burst_q, burst_d;
    logic cont, rel, can_acc, acc, pk_valid, sel_valid;
    logic [SW-1:0] pk_start, pk_sel, sel;

    // A lock continues on its owner; on release the scan restarts just past the owner.
    assign cont      = (state_q == ARB_LOCK) && src_valid[owner_q] && (burst_q < 4'(MAX_BURST));
    assign rel       = (state_q == ARB_LOCK) && !cont;
    assign pk_start  = rel ? SW'(rr_next(int'(owner_q), N_SRC)) : rr_q;
    assign sel       = cont ? owner_q : pk_sel;
    assign sel_valid = cont || pk_valid;
    assign can_acc   = arb_en && (!out_valid || out_ready);
    assign acc       = can_acc && sel_valid;
    assign src_ready = (rst_n && acc) ? (N_SRC'(1) << sel) : '0;

    cpm_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .valid    (src_valid),
        .start    (pk_start),
        .sel      (pk_sel),
        .sel_valid(pk_valid)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        if (!arb_en) begin
            state_d = ARB_IDLE;
            burst_d = '0;
        end else if (can_acc) begin
            if (state_q == ARB_IDLE) begin
                if (acc && MAX_BURST == 1) begin
                    rr_d = SW'(rr_next(int'(sel), N_SRC));
                end else if (acc) begin
                    owner_d = sel;
                    burst_d = 4'd1;
                    state_d = ARB_LOCK;
                end
            end else if (cont) begin
                burst_d = burst_q + 4'd1;
            end else begin
                rr_d    = SW'(rr_next(int'(owner_q), N_SRC));
                state_d = acc ? ARB_LOCK : ARB_IDLE;
                owner_d = acc ? sel : owner_q;
                burst_d = acc ? 4'd1 : burst_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            burst_q     <= '0;
            out_valid   <= 1'b0;
            out_id      <= '0;
            out_opcode  <= '0;
            out_payload <= '0;
            out_src     <= '0;
            grant_cnt   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            if (acc) begin
                out_valid   <= 1'b1;
                out_id      <= src_id[sel];
                out_opcode  <= src_opcode[sel];
                out_payload <= src_payload[sel];
                out_src     <= sel;
                grant_cnt   <= grant_cnt + 32'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpm_ingress_arb.sv
// tb_cpm_ingress_arb: burst-4 and pure round-robin arbiters against a grant/scoreboard reference.
module tb_cpm_ingress_arb;

    localparam int N = 4;

    logic clk = 1'b0, rst_n = 1'b0, arb_en = 1'b0, out_ready = 1'b0;
    logic [N-1:0] src_valid = '0;
    logic [N-1:0][3:0] src_id = '0, src_opcode = '0;
    logic [N-1:0][15:0] src_payload = '0;
    logic [N-1:0] rdy [2];
    logic ov [2];
    logic [3:0] oid [2], oop [2];
    logic [15:0] opay [2];
    logic [1:0] osrc [2];
    logic [31:0] gcnt [2];

    int errors = 0, checks = 0;
    int rr [2], owner [2], taken [2];
    bit locked [2];
    logic [31:0] mg [2];
    logic [25:0] q0 [$], q1 [$];

    always #5 clk = ~clk;

    cpm_ingress_arb #(.N_SRC(N), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .src_valid(src_valid), .src_ready(rdy[0]),
        .src_id(src_id), .src_opcode(src_opcode), .src_payload(src_payload),
        .out_valid(ov[0]), .out_ready(out_ready), .out_id(oid[0]), .out_opcode(oop[0]),
        .out_payload(opay[0]), .out_src(osrc[0]), .grant_cnt(gcnt[0])
    );

    cpm_ingress_arb #(.N_SRC(N), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .src_valid(src_valid), .src_ready(rdy[1]),
        .src_id(src_id), .src_opcode(src_opcode), .src_payload(src_payload),
        .out_valid(ov[1]), .out_ready(out_ready), .out_id(oid[1]), .out_opcode(oop[1]),
        .out_payload(opay[1]), .out_src(osrc[1]), .grant_cnt(gcnt[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [25:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic new_data();
        for (int p = 0; p < N; p++) begin
            src_id[p]      = 4'($urandom);
            src_opcode[p]  = 4'($urandom);
            src_payload[p] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rdy_in_reset%0d", d), rdy[d], 0);
            rr[d] = 0; owner[d] = 0; taken[d] = 0; locked[d] = 0; mg[d] = 0;
        end
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    // One clock: compare against the reference before the edge, advance it after.
    task automatic cycle();
        bit hs [2], acc [2], ca [2], cont [2];
        int w [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int start;
            bit wv;
            wv = 0;
            w[d] = 0;
            cont[d] = locked[d] && src_valid[owner[d]] && taken[d] < mb(d);
            if (cont[d]) begin
                w[d] = owner[d];
                wv = 1;
            end else begin
                start = locked[d] ? (owner[d] + 1) % N : rr[d];
                for (int k = N - 1; k >= 0; k--)
                    if (src_valid[(start + k) % N]) begin
                        w[d] = (start + k) % N;
                        wv = 1;
                    end
            end
            ca[d]  = arb_en && (qsz(d) == 0 || out_ready);
            acc[d] = ca[d] && wv;
            check($sformatf("src_ready%0d", d), rdy[d], acc[d] ? (1 << w[d]) : 0);
            check($sformatf("out_valid%0d", d), ov[d], qsz(d) > 0);
            if (qsz(d) > 0)
                check($sformatf("beat%0d", d), {osrc[d], oid[d], oop[d], opay[d]}, qfront(d));
            check($sformatf("grant_cnt%0d", d), gcnt[d], mg[d]);
            hs[d] = qsz(d) > 0 && out_ready;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (hs[d]) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (acc[d]) begin
                if (d == 0) q0.push_back({2'(w[d]), src_id[w[d]], src_opcode[w[d]], src_payload[w[d]]});
                else        q1.push_back({2'(w[d]), src_id[w[d]], src_opcode[w[d]], src_payload[w[d]]});
                mg[d] = mg[d] + 32'd1;
            end
            if (!arb_en) locked[d] = 0;
            else if (ca[d]) begin
                if (acc[d] && mb(d) == 1) rr[d] = (w[d] + 1) % N;
                else if (cont[d]) taken[d]++;
                else begin
                    if (locked[d]) rr[d] = (owner[d] + 1) % N;
                    locked[d] = acc[d];
                    if (acc[d]) begin
                        owner[d] = w[d];
                        taken[d] = 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic run(input logic [N-1:0] sv, input logic rdy_in, input int n);
        src_valid = sv;
        out_ready = rdy_in;
        for (int i = 0; i < n; i++) begin
            new_data();
            cycle();
        end
    endtask

    initial begin
        new_data();
        src_valid = '1;
        arb_en = 1'b1;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_out_valid%0d", d), ov[d], 0);
            check($sformatf("rst_grant%0d", d), gcnt[d], 0);
            check($sformatf("rst_out_src%0d", d), osrc[d], 0);
            check($sformatf("rst_payload%0d", d), opay[d], 0);
        end
        run(4'b1111, 1'b1, 8);
        run(4'b0101, 1'b1, 12);
        do_reset();
        run(4'b0010, 1'b1, 2);
        run(4'b1000, 1'b1, 2);
        src_valid = 4'b1111;
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) src_payload[p] = 16'hA5A5;
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            new_data();
            cycle();
            check("stall_payload", opay[0], 16'hA5A5);
        end
        run(4'b1111, 1'b1, 4);
        run(4'b0100, 1'b1, 10);
        run(4'b1111, 1'b1, 2);
        do_reset();
        check("midburst_rst_valid", ov[0], 0);
        check("midburst_rst_grant", gcnt[0], 0);
        run(4'b1111, 1'b1, 1);
        check("first_after_rst_src", osrc[0], 0);
        run(4'b1111, 1'b0, 1);
        arb_en = 1'b0;
        run(4'b1111, 1'b0, 2);
        run(4'b1111, 1'b1, 3);
        arb_en = 1'b1;
        run(4'b1111, 1'b1, 3);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3, 0) == 0) src_valid = 4'($urandom);
            arb_en    = $urandom_range(15, 0) != 0;
            out_ready = $urandom_range(3, 0) != 0;
            new_data();
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
